// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
//   fetch_state_e  : sequencer states (REQ drive request, WAIT outstanding, HOLD paused)
//   fetch_bundle_t : two-slot instruction bundle handed to the IFU front end
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int unsigned FETCH_BYTES      = 8;
  localparam logic [31:0] BLOCK_MASK       = ~32'(FETCH_BYTES - 1);
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [1:0]  valid;
    logic [31:0] pc;
    logic [63:0] data;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch block address helper (purely combinational).
//   pc        : in  - any fetch PC
//   block_pc  : out - pc aligned down to its 8-byte block
//   slot_mask : out - {slot1,slot0} valid; slot0 skipped when pc points at block+4
//   next_pc   : out - base of the following block, wraps modulo 2^32
module fetch_pc_gen
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] block_pc,
  output logic [1:0]  slot_mask,
  output logic [31:0] next_pc
);

  always_comb begin
    block_pc  = pc & BLOCK_MASK;
    slot_mask = pc[2] ? 2'b10 : 2'b11;
    next_pc   = {pc[31:3] + 29'd1, 3'b000};
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer between the I-cache request port and the IFU front end.
//   clk, rst          : clock, synchronous active-low reset
//   ib_pause          : instruction buffer nearly full, stop issuing
//   redirect_valid/pc : backend redirect strobe and target
//   ic_req_*          : I-cache request (valid/ready, 8-byte aligned pc)
//   ic_resp_*         : I-cache response, one cycle, one per accepted request
//   out_valid/pc/data : bundle to the IFU, valid only in the response cycle
//   busy              : a request is outstanding (possibly a stale one)
// Optional build macro FETCH_CTRL_PERF_EN adds saturating counters
//   perf_pause_cycles, perf_stale_drops, perf_blocks.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ib_pause,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_pc,
  input  logic        ic_req_ready,
  input  logic        ic_resp_valid,
  input  logic [63:0] ic_resp_data,
  output logic [1:0]  out_valid,
  output logic [31:0] out_pc,
  output logic [63:0] out_data,
  output logic        busy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_pause_cycles,
  output logic [15:0] perf_stale_drops,
  output logic [31:0] perf_blocks
`endif
);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          stale_q, stale_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [1:0]    mask_q, mask_d;

  logic [31:0]   gen_pc, gen_block, gen_next;
  logic [1:0]    gen_mask;
  logic          req_fire, resp_in_wait, deliver;
  fetch_bundle_t bundle;

  // While waiting, the helper works on the latched request to form the next block;
  // otherwise it aligns the current fetch PC for the request port.
  assign gen_pc = (state_q == WAIT) ? req_pc_q : fetch_pc_q;

  fetch_pc_gen u_pc_gen (
    .pc        (gen_pc),
    .block_pc  (gen_block),
    .slot_mask (gen_mask),
    .next_pc   (gen_next)
  );

  // Request/response qualifiers and the combinational bundle pass-through
  always_comb begin
    ic_req_valid = rst && (state_q == REQ) && !ib_pause && !redirect_valid;
    ic_req_pc    = rst ? gen_block : (RESET_PC & BLOCK_MASK);
    req_fire     = ic_req_valid && ic_req_ready;
    resp_in_wait = rst && (state_q == WAIT) && ic_resp_valid;
    deliver      = resp_in_wait && !stale_q && !redirect_valid;
    busy         = rst && (state_q == WAIT);

    bundle = '0;
    if (deliver) begin
      bundle.valid = mask_q;
      bundle.pc    = req_pc_q;
      bundle.data  = ic_resp_data;
    end
    out_valid = bundle.valid;
    out_pc    = bundle.pc;
    out_data  = bundle.data;
  end

  // Next-state logic; redirect overrides everything else
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    req_pc_d   = req_pc_q;
    mask_d     = mask_q;

    if (req_fire) begin
      req_pc_d = gen_block;
      mask_d   = gen_mask;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & WORD_MASK;
      if (resp_in_wait) begin
        // The coincident response closes the outstanding request.
        state_d = REQ;
        stale_d = 1'b0;
      end else if ((state_q == WAIT) || req_fire) begin
        state_d = WAIT;
        stale_d = 1'b1;
      end else begin
        state_d = REQ;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (req_fire)      state_d = WAIT;
          else if (ib_pause) state_d = HOLD;
        end
        HOLD: begin
          if (!ib_pause) state_d = REQ;
        end
        WAIT: begin
          if (ic_resp_valid) begin
            if (stale_q) begin
              stale_d = 1'b0;
              state_d = REQ;
            end else begin
              fetch_pc_d = gen_next;
              state_d    = ib_pause ? HOLD : REQ;
            end
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      stale_q    <= 1'b0;
      req_pc_q   <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
      req_pc_q   <= req_pc_d;
      mask_q     <= mask_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] pause_cnt_q, pause_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic        drop_c;

  // Saturating event counters
  always_comb begin
    drop_c      = resp_in_wait && (stale_q || redirect_valid);
    pause_cnt_d = pause_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    if ((state_q == HOLD) && (pause_cnt_q != '1)) pause_cnt_d = pause_cnt_q + 32'd1;
    if (drop_c && (drop_cnt_q != '1))             drop_cnt_d  = drop_cnt_q + 16'd1;
    if (deliver && (blk_cnt_q != '1))             blk_cnt_d   = blk_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pause_cnt_q <= '0;
      drop_cnt_q  <= '0;
      blk_cnt_q   <= '0;
    end else begin
      pause_cnt_q <= pause_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign perf_pause_cycles = pause_cnt_q;
  assign perf_stale_drops  = drop_cnt_q;
  assign perf_blocks       = blk_cnt_q;
`endif

endmodule
